serial_magnitude_comparator: RTL and testbench
==============================================

# serial_magnitude_comparator

Multi-cycle, parametrised magnitude comparator. It latches two WIDTH-bit operands on a start request and compares them one DIGIT-bit slice per clock, most significant slice first. It terminates early on the first differing slice and reports one-hot registered less/greater/equal flags with a done pulse. It is the parametrised successor to the single-cycle 4-bit registered comparator: it adds width/slice parameters, a runtime signed mode and a start/busy/done handshake, and is used wherever wide operands must be ordered without a wide single-cycle compare path.

## Interface
- WIDTH, 16: operand width in bits; must be a multiple of DIGIT.
- DIGIT, 4: bits compared per clock; N = WIDTH/DIGIT slices.
- CLK  in  1  clock; all state changes on the rising edge.
- RST  in  1  asynchronous, active-high reset.
- START  in  1  request; sampled only when BUSY=0.
- SIGNED_MODE  in  1  1 = two's-complement compare, 0 = unsigned; latched with the operands.
- A  in  WIDTH  operand A; latched on an accepted START.
- B  in  WIDTH  operand B; latched on an accepted START.
- BUSY  out  1  comparison in progress.
- DONE  out  1  one-cycle pulse; the flags are valid and newly updated.
- A_lt_B  out  1  result flag A < B.
- A_gt_B  out  1  result flag A > B.
- A_eq_B  out  1  result flag A == B.

## Operation
- States: IDLE, CMP.
- IDLE with START=1: latch A, B and SIGNED_MODE. Set the slice index to N-1. Go to CMP.
- IDLE with START=0: hold state.
- In signed mode, invert bit WIDTH-1 of both latched operands. This gives an offset-binary view, so the unsigned slice compare is then correct.
- CMP, each edge: compare slice[idx] of A against slice[idx] of B.
  - If A slice > B slice: register A_gt_B=1, others 0. Pulse DONE. Go to IDLE.
  - If A slice < B slice: register A_lt_B=1, others 0. Pulse DONE. Go to IDLE.
  - If equal and idx=0: register A_eq_B=1, others 0. Pulse DONE. Go to IDLE.
  - If equal and idx>0: decrement idx and stay in CMP.
- BUSY = (state == CMP).
- Flags keep the previous result until the next DONE. They are not cleared when a new START is accepted.
- After the first completion, exactly one flag is 1.
- START while BUSY=1 is ignored: no re-latch and no queuing.
- Changes on A, B or SIGNED_MODE after acceptance have no effect on the comparison in flight.
- Reset values: state=IDLE, BUSY=0, DONE=0, A_lt_B=0, A_gt_B=0, A_eq_B=0, idx=0.

## Timing
- START accepted at edge t0. BUSY is high from t0 until the deciding edge.
- The first differing slice at position k (counting from the MSB, k=1..N) decides at edge t0+k.
- Flags and DONE change at edge t0+k. DONE is high for exactly one cycle. BUSY falls at the same edge.
- Latency: minimum 1 cycle (MSB slices differ), maximum N cycles (equal operands, or only the LSB slice differs).
- Back-to-back operation: START may be high during the DONE cycle. It is accepted at the next edge, giving zero idle cycles.
- RST is asynchronous. Asserting it mid-CMP immediately forces all outputs to their reset values and aborts the comparison, with no DONE.
- The first START is sampled at the first rising edge after RST deasserts.

## Test plan
- Reset: RST=1 with START=1 and toggling operands -> BUSY=0, DONE=0 and all flags 0 throughout. After release with START=0, everything stays 0.
- Early exit (unsigned): A=16'hF000, B=16'h0FFF, START at t0 -> at t0+1, A_gt_B=1 and DONE=1. BUSY is high for one cycle only.
- Full-length: A=B=16'h1234 -> A_eq_B=1 and DONE=1 at t0+4. A=16'h1234, B=16'h1235 -> A_lt_B=1 at t0+4.
- Signed mode: A=16'h8000, B=16'h0001, SIGNED_MODE=1 -> A_lt_B=1 at t0+1. The same operands with SIGNED_MODE=0 -> A_gt_B=1 at t0+1. A=16'hFFFF, B=16'hFFFE, SIGNED_MODE=1 -> A_gt_B=1 at t0+4.
- Handshake: a START pulse during BUSY with new operands -> ignored, and the original result is reported. START held high through a DONE cycle -> second compare accepted at the next edge, and its DONE arrives per the latency rule.
- Reset mid-operation: A=B=16'hABCD, RST=1 pulsed at t0+2 -> outputs 0 immediately and no DONE. A new START after release completes normally with A_eq_B=1.

Source files
------------

// File: rtl/serial_magnitude_comparator.sv
// Multi-cycle magnitude comparator. It compares two latched operands one DIGIT-bit slice
// per clock, starting at the most significant slice, and stops at the first slice that differs.
module serial_magnitude_comparator #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             signed_mode_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             a_lt_b_o,
    output logic             a_gt_b_o,
    output logic             a_eq_b_o
);

    localparam int N     = WIDTH / DIGIT;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N - 1);

    typedef enum logic {
        IDLE = 1'b0,
        CMP  = 1'b1
    } state_e;

    state_e           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [IDX_W-1:0] idx_q;
    logic             done_q;
    logic             lt_q;
    logic             gt_q;
    logic             eq_q;

    // Flipping the sign bit of both operands maps two's complement onto offset binary,
    // so a plain unsigned compare of the slices gives the signed ordering.
    logic [WIDTH-1:0] msb_flip;
    assign msb_flip = {signed_mode_i, {(WIDTH-1){1'b0}}};

    // The operands shift left as the compare proceeds, so the active slice is always the top one.
    logic [DIGIT-1:0] a_top;
    logic [DIGIT-1:0] b_top;
    assign a_top = a_q[WIDTH-1 -: DIGIT];
    assign b_top = b_q[WIDTH-1 -: DIGIT];

    // NOTE: sequential state uses non-blocking assignments only, so every register in this
    // block samples the values that were present before the edge.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            idx_q   <= '0;
            done_q  <= 1'b0;
            lt_q    <= 1'b0;
            gt_q    <= 1'b0;
            eq_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        a_q     <= a_i ^ msb_flip;
                        b_q     <= b_i ^ msb_flip;
                        idx_q   <= IDX_LAST;
                        state_q <= CMP;
                    end
                end
                CMP: begin
                    if ((a_top != b_top) || (idx_q == '0)) begin
                        lt_q    <= (a_top < b_top);
                        gt_q    <= (a_top > b_top);
                        eq_q    <= (a_top == b_top);
                        done_q  <= 1'b1;
                        state_q <= IDLE;
                    end else begin
                        idx_q <= idx_q - 1'b1;
                        a_q   <= a_q << DIGIT;
                        b_q   <= b_q << DIGIT;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy_o   = (state_q == CMP);
    assign done_o   = done_q;
    assign a_lt_b_o = lt_q;
    assign a_gt_b_o = gt_q;
    assign a_eq_b_o = eq_q;

endmodule

// File: tb/tb_serial_magnitude_comparator.sv
// Self-checking bench for serial_magnitude_comparator: directed table, handshake and reset
// sequences, and random operands checked against an arithmetic reference model.
module tb_serial_magnitude_comparator;

    localparam int W = 16;
    localparam int D = 4;
    localparam int N = W / D;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic         sm = 1'b0;
    logic [W-1:0] a_in = '0;
    logic [W-1:0] b_in = '0;
    logic         busy, done, lt, gt, eq;

    int vectors = 0;
    int miscompares = 0;
    logic [2:0] prev_flags = 3'b000;  // {lt, gt, eq} of the last completed compare

    serial_magnitude_comparator #(.WIDTH(W), .DIGIT(D)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .signed_mode_i(sm),
        .a_i(a_in), .b_i(b_in), .busy_o(busy), .done_o(done),
        .a_lt_b_o(lt), .a_gt_b_o(gt), .a_eq_b_o(eq)
    );

    always #5 clk = ~clk;

    typedef struct {
        string        name;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         sm;
        logic [2:0]   flags;
        int           lat;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Ordering from plain integer compare; latency is the position of the first differing slice.
    task automatic ref_model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                             output logic [2:0] flags, output int lat);
        logic signed [W-1:0] sa, sb;
        int ua, ub;
        bit found;
        sa = a; sb = b;
        ua = int'(a); ub = int'(b);
        if (s) flags = {sa < sb, sa > sb, sa == sb};
        else   flags = {ua < ub, ua > ub, ua == ub};
        lat = N;
        found = 0;
        for (int k = 1; k <= N; k++) begin
            if (!found && (((ua >> (W - k * D)) & 15) != ((ub >> (W - k * D)) & 15))) begin
                lat = k;
                found = 1;
            end
        end
    endtask

    task automatic run_cmp(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic s, input logic [2:0] exp_flags, input int exp_lat);
        int  lat;
        bit  got;
        @(negedge clk);
        start = 1'b1; a_in = a; b_in = b; sm = s;
        @(posedge clk); #1;
        start = 1'b0;
        a_in = W'($urandom); b_in = W'($urandom); sm = 1'($urandom);
        check({tag, " busy after accept"}, 32'(busy), 32'd1);
        check({tag, " flags held on accept"}, 32'({lt, gt, eq}), 32'(prev_flags));
        lat = 0; got = 0;
        for (int c = 1; c <= N + 2 && !got; c++) begin
            @(posedge clk); #1;
            if (done) begin
                got = 1;
                lat = c;
            end
        end
        check({tag, " latency"}, 32'(lat), 32'(exp_lat));
        check({tag, " flags"}, 32'({lt, gt, eq}), 32'(exp_flags));
        check({tag, " busy at done"}, 32'(busy), 32'd0);
        prev_flags = exp_flags;
        @(posedge clk); #1;
        check({tag, " done one cycle"}, 32'(done), 32'd0);
        check({tag, " flags persist"}, 32'({lt, gt, eq}), 32'(exp_flags));
    endtask

    initial begin
        logic [2:0] f;
        int lat;
        int got_lat;

        vecs.push_back('{"early_gt",   16'hF000, 16'h0FFF, 1'b0, 3'b010, 1});
        vecs.push_back('{"full_eq",    16'h1234, 16'h1234, 1'b0, 3'b001, 4});
        vecs.push_back('{"full_lt",    16'h1234, 16'h1235, 1'b0, 3'b100, 4});
        vecs.push_back('{"signed_lt",  16'h8000, 16'h0001, 1'b1, 3'b100, 1});
        vecs.push_back('{"unsig_gt",   16'h8000, 16'h0001, 1'b0, 3'b010, 1});
        vecs.push_back('{"signed_m1",  16'hFFFF, 16'hFFFE, 1'b1, 3'b010, 4});
        vecs.push_back('{"signed_eq0", 16'h0000, 16'h0000, 1'b1, 3'b001, 4});
        vecs.push_back('{"signed_max", 16'h7FFF, 16'h8000, 1'b1, 3'b010, 1});
        vecs.push_back('{"unsig_max",  16'h7FFF, 16'h8000, 1'b0, 3'b100, 1});
        vecs.push_back('{"slice2_lt",  16'h1200, 16'h1300, 1'b0, 3'b100, 2});
        vecs.push_back('{"slice3_gt",  16'hAB50, 16'hAB4F, 1'b1, 3'b010, 3});

        // Reset held with START high and moving operands: everything stays zero.
        start = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check("reset outputs", 32'({busy, done, lt, gt, eq}), 32'd0);
            a_in = W'($urandom); b_in = W'($urandom); sm = 1'($urandom);
        end
        @(negedge clk);
        start = 1'b0; rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("post-reset idle", 32'({busy, done, lt, gt, eq}), 32'd0);
        end

        foreach (vecs[i])
            run_cmp(vecs[i].name, vecs[i].a, vecs[i].b, vecs[i].sm, vecs[i].flags, vecs[i].lat);

        // START pulsed mid-compare with new operands must be ignored.
        @(negedge clk);
        start = 1'b1; a_in = 16'h1234; b_in = 16'h1234; sm = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        start = 1'b1; a_in = 16'h0000; b_in = 16'hFFFF;
        @(negedge clk);
        start = 1'b0;
        got_lat = 0;
        for (int c = 2; c <= N + 2 && got_lat == 0; c++) begin
            @(posedge clk); #1;
            if (done) got_lat = c;
        end
        check("ignored start latency", 32'(got_lat), 32'd4);
        check("ignored start flags", 32'({lt, gt, eq}), 32'b001);
        @(posedge clk); #1;
        check("ignored start no requeue", 32'({busy, done}), 32'd0);
        prev_flags = 3'b001;

        // START held through DONE: the second compare is accepted on the edge after DONE.
        @(negedge clk);
        start = 1'b1; a_in = 16'hF000; b_in = 16'h0FFF; sm = 1'b0;
        @(posedge clk); #1;
        a_in = 16'h1234; b_in = 16'h1235;
        @(posedge clk); #1;
        check("b2b first done", 32'({done, lt, gt, eq}), 32'b1010);
        @(posedge clk); #1;
        check("b2b second accept", 32'({busy, done}), 32'b10);
        start = 1'b0;
        got_lat = 0;
        for (int c = 1; c <= N + 2 && got_lat == 0; c++) begin
            @(posedge clk); #1;
            if (done) got_lat = c;
        end
        check("b2b second latency", 32'(got_lat), 32'd4);
        check("b2b second flags", 32'({lt, gt, eq}), 32'b100);
        prev_flags = 3'b100;

        // Asynchronous reset in the middle of a compare aborts it with no DONE.
        @(negedge clk);
        start = 1'b1; a_in = 16'hABCD; b_in = 16'hABCD; sm = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        check("abort busy before reset", 32'(busy), 32'd1);
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        check("abort immediate clear", 32'({busy, done, lt, gt, eq}), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("abort held", 32'({busy, done, lt, gt, eq}), 32'd0);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        check("abort no done", 32'({busy, done}), 32'd0);
        prev_flags = 3'b000;
        run_cmp("after_abort", 16'hABCD, 16'hABCD, 1'b0, 3'b001, 4);

        // Random operands, biased so that many pairs share their upper slices.
        for (int i = 0; i < 40; i++) begin
            logic [W-1:0] ra, rb;
            logic rs;
            ra = W'($urandom);
            rb = ra ^ (W'($urandom_range(0, 15)) << (D * $urandom_range(0, N - 1)));
            if ($urandom_range(0, 3) == 0) rb = W'($urandom);
            rs = 1'($urandom);
            ref_model(ra, rb, rs, f, lat);
            run_cmp("random", ra, rb, rs, f, lat);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
